// File: rtl/prog_loader.sv
// prog_loader: banked run-time memories streamed out as framed serial
// packets, then core run supervision with done handshake and timeout.
module prog_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NBANKS = 2,
  parameter int CLK_DIV = 2,
  parameter int RUN_TIMEOUT = 0,
  localparam int FRAME_W = 1 + DATA_W + ADDR_W,
  localparam int MODE_W = $clog2(NBANKS + 2),
  localparam int BSEL_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BSEL_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   len_in,
  input  logic              start,
  input  logic              done_in,
  output logic              mosi_out,
  output logic              sclk_out,
  output logic [MODE_W-1:0] mode_out,
  output logic              busy,
  output logic              done_out,
  output logic              timeout_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BIT_W = $clog2(FRAME_W);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int RUN_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
  localparam logic [BSEL_W:0]   NB = (BSEL_W + 1)'(NBANKS);
  localparam logic [BSEL_W-1:0] B_LAST = BSEL_W'(NBANKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0]  SETUP_LAST = DIV_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [MODE_W-1:0] MODE_RUN = MODE_W'(NBANKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_RUN, S_FIN
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0]  mem [NBANKS][DEPTH];
  logic [ADDR_W:0]    len_q;
  logic [BSEL_W-1:0]  b;
  logic [ADDR_W-1:0]  w;
  logic [DIV_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_i;
  logic [RUN_W-1:0]   run_cnt;
  logic               timeout_q;
  logic [FRAME_W-1:0] frame;
  logic [MODE_W-1:0]  bank_mode;
  logic               w_last, b_last, bit_end, run_to;

  // memory is deliberately left out of reset so programs survive rst
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE && {1'b0, wr_bank} < NB)
      mem[wr_bank][wr_addr] <= wr_data;
  end

  assign frame = {1'b0, mem[b][w], w};
  assign bank_mode = MODE_W'(b) + MODE_W'(1);
  assign w_last = ({1'b0, w} == len_q - 1'b1);
  assign b_last = (b == B_LAST);
  assign bit_end = (cnt == DIV_LAST);
  assign run_to = (RUN_TIMEOUT != 0) && (run_cnt == RUN_LAST);
  assign timeout_out = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:
        if (start) state_d = (len_in == '0) ? S_RUN : S_SETUP;
      S_SETUP:
        if (cnt == SETUP_LAST) state_d = S_SHIFT;
      S_SHIFT:
        if (bit_end && bit_i == BIT_LAST) state_d = S_GAP;
      S_GAP:
        state_d = (w_last && b_last) ? S_RUN : S_SETUP;
      S_RUN:
        if (done_in || run_to) state_d = S_FIN;
      S_FIN:
        if (!start) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_out = '0;
    mosi_out = 1'b0;
    sclk_out = 1'b0;
    busy = (state != S_IDLE);
    done_out = 1'b0;
    unique case (state)
      S_SETUP: begin
        mode_out = bank_mode;
        mosi_out = frame[0];
      end
      S_SHIFT: begin
        mode_out = bank_mode;
        mosi_out = frame[bit_i];
        sclk_out = (cnt >= DIV_HALF);
      end
      S_RUN: mode_out = MODE_RUN;
      S_FIN: done_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      b <= '0;
      w <= '0;
      cnt <= '0;
      bit_i <= '0;
      run_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          bit_i <= '0;
          b <= '0;
          w <= '0;
          if (start) begin
            len_q <= len_in;
            timeout_q <= 1'b0;
          end
        end
        S_SETUP:
          cnt <= (cnt == SETUP_LAST) ? '0 : cnt + 1'b1;
        S_SHIFT:
          if (bit_end) begin
            cnt <= '0;
            bit_i <= bit_i + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        S_GAP: begin
          cnt <= '0;
          bit_i <= '0;
          if (!w_last) begin
            w <= w + 1'b1;
          end else if (!b_last) begin
            b <= b + 1'b1;
            w <= '0;
          end
        end
        S_RUN:
          if (run_to && !done_in) timeout_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed load/run sequences with a frame scoreboard
// fed at start and drained by a serial-line monitor.
module tb_prog_loader;

  typedef struct packed {
    logic [1:0]  mode;
    logic [12:0] frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [0:0] wr_bank = '0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] len_in = '0;
  logic       start = 1'b0;
  logic       done_in = 1'b0;
  logic       start2 = 1'b0;
  logic       done2 = 1'b0;

  logic       mosi_out, sclk_out, busy, done_out, timeout_out;
  logic [1:0] mode_out;
  logic       mosi2, sclk2, busy2, done_out2, timeout2;
  logic [1:0] mode2;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [7:0] mm [2][16];

  prog_loader #(.RUN_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .len_in(len_in),
    .start(start), .done_in(done_in), .mosi_out(mosi_out),
    .sclk_out(sclk_out), .mode_out(mode_out), .busy(busy),
    .done_out(done_out), .timeout_out(timeout_out)
  );

  prog_loader #(.CLK_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .len_in(len_in),
    .start(start2), .done_in(done2), .mosi_out(mosi2),
    .sclk_out(sclk2), .mode_out(mode2), .busy(busy2),
    .done_out(done_out2), .timeout_out(timeout2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int bk, input int a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_bank = bk[0:0];
    wr_addr = a[3:0];
    wr_data = d;
    mm[bk][a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push(input int len);
    exp_t e;
    for (int bk = 0; bk < 2; bk++)
      for (int wi = 0; wi < len; wi++) begin
        e.mode = 2'(bk + 1);
        e.frame = {1'b0, mm[bk][wi], 4'(wi)};
        sb.push_back(e);
      end
  endtask

  task automatic wait_mode(input logic [1:0] m, output int n);
    n = 0;
    while (mode_out !== m && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_run(input string tag);
    done_in = 1'b1;
    tick();
    chk({tag, "_fin"}, {done_out, mode_out}, 3'b100);
    done_in = 1'b0;
    tick();
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic load(input int len, input int cyc, input string tag);
    int n;
    len_in = 5'(len);
    start = 1'b1;
    push(len);
    tick();
    start = 1'b0;
    wait_mode(2'd3, n);
    chk({tag, "_cycles"}, n, cyc);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // serial-line monitor: rebuilds each frame and checks it against the queue
  initial begin : mon
    logic [12:0] cap;
    logic [1:0]  bm;
    logic        inf, psclk;
    int          nb, cyc, hi;
    exp_t        e;
    inf = 1'b0;
    psclk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inf = 1'b0;
        psclk = 1'b0;
      end else if (mode_out inside {2'd1, 2'd2}) begin
        if (!inf) begin
          inf = 1'b1;
          cap = '0;
          nb = 0;
          cyc = 0;
          hi = 0;
          bm = mode_out;
        end
        cyc++;
        if (sclk_out) hi++;
        if (sclk_out && !psclk && nb < 13) begin
          cap[nb] = mosi_out;
          nb++;
        end
        psclk = sclk_out;
      end else if (inf) begin
        inf = 1'b0;
        psclk = 1'b0;
        chk("frame_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("frame_data", {bm, cap}, {e.mode, e.frame});
          chk("frame_timing", {cyc[15:0], hi[15:0]}, {16'd28, 16'd13});
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic [12:0] fr;
    logic [53:0] os, es, om, em;

    repeat (3) tick();
    chk("rst_outs", {mode_out, mosi_out, sclk_out, busy, done_out,
                     timeout_out}, 7'd0);
    chk("rst_outs2", {mode2, mosi2, sclk2, busy2, done_out2, timeout2},
        7'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      wr(0, i, 8'(8'h10 + i));
      wr(1, i, 8'(8'hA0 + i));
    end

    len_in = 5'd16;
    start = 1'b1;
    push(16);
    tick();
    start = 1'b0;
    chk("t2_first_mode", mode_out, 2'd1);
    wait_mode(2'd3, n);
    chk("t2_load_cycles", n, 928);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_run_busy", busy, 1'b1);

    done_in = 1'b1;
    start = 1'b1;
    tick();
    chk("t3_fin", {done_out, mode_out}, 3'b100);
    done_in = 1'b0;
    repeat (3) tick();
    chk("t3_hold_fin", done_out, 1'b1);
    start = 1'b0;
    tick();
    chk("t3_idle", {busy, done_out}, 2'b00);

    len_in = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_len0_run", mode_out, 2'd3);
    n = 0;
    while (done_out !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 100);
    chk("t4_timeout_flag", timeout_out, 1'b1);
    tick();
    chk("t4_sticky", {busy, timeout_out}, 2'b01);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_clear", {mode_out, timeout_out}, 3'b110);
    repeat (99) tick();
    done_in = 1'b1;
    tick();
    chk("t4_done_wins", {done_out, timeout_out}, 2'b10);
    done_in = 1'b0;
    tick();
    chk("t4_idle", busy, 1'b0);

    len_in = 5'd3;
    start = 1'b1;
    push(3);
    tick();
    start = 1'b0;
    repeat (5) tick();
    wr_en = 1'b1;
    wr_bank = 1'b0;
    wr_addr = 4'd1;
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    wait_mode(2'd3, n);
    chk("t5_cycles", n, 168);
    chk("t5_sb_empty", sb.size(), 0);
    finish_run("t5");
    load(3, 174, "t5_rerun");
    finish_run("t5_rerun");

    wr_en = 1'b1;
    wr_bank = 1'b1;
    wr_addr = 4'd0;
    wr_data = 8'h55;
    mm[1][0] = 8'h55;
    load(1, 58, "t5_wr_start");
    wr_en = 1'b0;
    finish_run("t5_wr_start");

    len_in = 5'd16;
    start = 1'b1;
    push(16);
    tick();
    start = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    tick();
    chk("t1_rst_outs", {mode_out, mosi_out, sclk_out, busy, done_out},
        6'd0);
    repeat (2) tick();
    rst = 1'b0;
    sb.delete();
    tick();
    chk("t6_idle_after_rst", busy, 1'b0);
    load(16, 928, "t6_reload");
    finish_run("t6_reload");

    len_in = 5'd1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    fr = {1'b0, mm[0][0], 4'd0};
    for (int c = 0; c < 54; c++) begin
      os[c] = sclk2;
      om[c] = mosi2;
      es[c] = (c >= 2) && (((c - 2) % 4) >= 2);
      em[c] = (c < 2) ? fr[0] : fr[(c - 2) / 4];
      tick();
    end
    chk("t6_div4_sclk", os, es);
    chk("t6_div4_mosi", om, em);
    chk("t6_div4_gap", {mode2, busy2}, 3'b001);
    n = 0;
    while (mode2 !== 2'd3 && n < 500) begin
      tick();
      n++;
    end
    chk("t6_div4_run", n, 56);
    done2 = 1'b1;
    tick();
    chk("t6_div4_fin", done_out2, 1'b1);
    done2 = 1'b0;
    tick();
    chk("t6_div4_idle", busy2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
